// File: rtl/hazard_irq_sequencer.sv
// Pipeline hazard unit (load-use stall, branch/jump flush) with an interrupt sequencer
// that injects an IRQ only at a safe instruction boundary. Define IRQ_SYNC_EN for a 2-flop ext_irq synchronizer.
module hazard_irq_sequencer #(
   parameter int HOLDOFF_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ext_irq,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       id_jump,
   input  logic       id_pc_super,
   input  logic       id_eret,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic       ex_branch_taken,
   output logic       irq_to_ctrl,
   output logic       pc_write,
   output logic       if_id_write,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic [1:0] irq_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_PEND    = 2'b01,
      S_SERVICE = 2'b10,
      S_HOLDOFF = 2'b11
   } state_t;

   localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF_CYCLES);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       irq_s;
   logic       load_use;
   logic       safe;

`ifdef IRQ_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= ext_irq;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = ext_irq;
`endif

   assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   // Kernel-mode instructions are never interrupted, so PC[31] also blocks injection.
   assign safe = !ex_branch_taken && !load_use && !id_jump && !id_pc_super;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      irq_to_ctrl = 1'b0;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;

      if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end else if (id_jump) begin
         if_id_flush = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (irq_s && !id_pc_super) state_d = S_PEND;
         end
         S_PEND: begin
            if (safe) begin
               irq_to_ctrl = 1'b1;
               if_id_flush = 1'b1;
               state_d     = S_SERVICE;
            end
         end
         S_SERVICE: begin
            if (id_eret && !load_use && !ex_branch_taken) begin
               if (HOLDOFF_CYCLES == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_HOLDOFF;
                  cnt_d   = HOLD_INIT;
               end
            end
         end
         S_HOLDOFF: begin
            // Leaving at a count of 1 gives exactly HOLDOFF_CYCLES cycles in this state.
            if (cnt_q <= 4'd1) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (reset) begin
         irq_to_ctrl = 1'b0;
         pc_write    = 1'b1;
         if_id_write = 1'b1;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end
   end

   assign irq_state = reset ? 2'b00 : state_q;

endmodule

// File: tb/tb_hazard_irq_sequencer.sv
// Directed bench for hazard_irq_sequencer: hazards, IRQ blocking, return/holdoff, reset and irq latency.
module tb_hazard_irq_sequencer;

`ifdef IRQ_SYNC_EN
   localparam int SYNC_LAT = 3;
`else
   localparam int SYNC_LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       reset, ext_irq, id_uses_rt, id_jump, id_pc_super, id_eret;
   logic       ex_mem_read, ex_branch_taken;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       irq_to_ctrl, pc_write, if_id_write, if_id_flush, id_ex_flush;
   logic [1:0] irq_state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_irq_sequencer #(.HOLDOFF_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .ext_irq(ext_irq),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_jump(id_jump), .id_pc_super(id_pc_super), .id_eret(id_eret),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
      .irq_to_ctrl(irq_to_ctrl), .pc_write(pc_write), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .irq_state(irq_state)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {irq_to_ctrl, pc_write, if_id_write, if_id_flush, id_ex_flush}
   function automatic logic [7:0] outs();
      return {3'b000, irq_to_ctrl, pc_write, if_id_write, if_id_flush, id_ex_flush};
   endfunction

   task automatic clr();
      ext_irq = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0;
      id_pc_super = 0; id_eret = 0; ex_mem_read = 0; ex_rt = 0; ex_branch_taken = 0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic load_use_r8();
      ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8;
   endtask

   initial begin
      int n;
      reset = 1;
      clr();
      mid();
      chk("reset_outs", outs(), 8'b01111);
      chk("reset_state", {6'd0, irq_state}, 8'd0);
      nxt();
      nxt(); reset = 0;
      mid();
      chk("idle_outs", outs(), 8'b01100);
      chk("idle_state", {6'd0, irq_state}, 8'd0);

      nxt(); load_use_r8();
      mid(); chk("lu_rs", outs(), 8'b00001);
      nxt(); clr();
      mid(); chk("lu_one_bubble", outs(), 8'b01100);
      nxt(); ex_mem_read = 1; ex_rt = 0; id_rs = 0;
      mid(); chk("lu_r0_nostall", outs(), 8'b01100);
      nxt(); clr(); ex_mem_read = 1; ex_rt = 9; id_rt = 9; id_rs = 3; id_uses_rt = 1;
      mid(); chk("lu_rt", outs(), 8'b00001);
      nxt(); id_uses_rt = 0;
      mid(); chk("lu_rt_unused", outs(), 8'b01100);
      nxt(); clr(); load_use_r8(); ex_branch_taken = 1;
      mid(); chk("branch_over_lu", outs(), 8'b01111);
      nxt(); clr(); id_jump = 1;
      mid(); chk("jump_flush", outs(), 8'b01110);
      nxt(); clr(); id_jump = 1; load_use_r8();
      mid(); chk("lu_over_jump", outs(), 8'b00001);

      // IRQ pulse while jumps hold the pipe unsafe for three cycles.
      nxt(); clr(); ext_irq = 1; id_jump = 1;
      mid(); chk("blk_c1_irq", {7'd0, irq_to_ctrl}, 8'd0);
      nxt(); ext_irq = 0;
      mid(); chk("blk_c2_irq", {7'd0, irq_to_ctrl}, 8'd0);
      nxt();
      mid(); chk("blk_c3_irq", {7'd0, irq_to_ctrl}, 8'd0);
      nxt(); clr();
      mid();
      chk("blk_pend_state", {6'd0, irq_state}, 8'd1);
      chk("blk_inject", outs(), 8'b11110);
      nxt(); ext_irq = 1;
      mid();
      chk("svc_state", {6'd0, irq_state}, 8'd2);
      chk("svc_no_irq", {7'd0, irq_to_ctrl}, 8'd0);
      nxt(); id_eret = 1; load_use_r8();
      mid(); chk("eret_lu_outs", outs(), 8'b00001);
      nxt(); ex_mem_read = 0; ex_rt = 0; id_rs = 0;
      mid(); chk("eret_lu_blocked", {6'd0, irq_state}, 8'd2);
      nxt(); id_eret = 0;
      mid(); chk("holdoff_1", {6'd0, irq_state}, 8'd3);
      nxt();
      mid();
      chk("holdoff_2", {6'd0, irq_state}, 8'd3);
      chk("holdoff_no_irq", {7'd0, irq_to_ctrl}, 8'd0);
      nxt();
      mid(); chk("after_holdoff_idle", {6'd0, irq_state}, 8'd0);
      nxt(); ext_irq = 0;
      mid();
      chk("repend_state", {6'd0, irq_state}, 8'd1);
      chk("repend_inject", {7'd0, irq_to_ctrl}, 8'd1);
      nxt();
      mid(); chk("svc2_state", {6'd0, irq_state}, 8'd2);

      nxt(); reset = 1;
      mid();
      chk("rst_svc_state", {6'd0, irq_state}, 8'd0);
      chk("rst_svc_outs", outs(), 8'b01111);
      nxt(); reset = 0;
      mid(); chk("rst_discard_1", {6'd0, irq_state}, 8'd0);
      nxt();
      mid(); chk("rst_discard_2", {6'd0, irq_state}, 8'd0);

      // Kernel-mode ID instruction keeps the sequencer idle.
      nxt(); ext_irq = 1; id_pc_super = 1;
      nxt();
      mid(); chk("super_block", {6'd0, irq_state}, 8'd0);
      reset = 1; clr();
      nxt(); nxt(); reset = 0;
      nxt(); nxt();
      mid(); chk("lat_pre_idle", {6'd0, irq_state}, 8'd0);

      nxt(); ext_irq = 1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         nxt();
         n++;
         if (irq_state == 2'b01) break;
      end
      chk("irq_latency", 8'(n), 8'(SYNC_LAT));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
